// File: rtl/exec_issue_fifo_if.sv
// Handshake bundle between dispatch, the issue buffer and exec.
interface exec_issue_fifo_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INFO_W = 32,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
);
  logic              in_valid;
  logic              in_ready;
  logic [INFO_W-1:0] in_info;
  logic              order;
  logic              accepted;
  logic [INFO_W-1:0] exec_info;
  logic              flush;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic [31:0]       stall_cycles;

  // Buffer side
  modport slave (
    input  in_valid, in_info, accepted, flush,
    output in_ready, order, exec_info, count, empty, full, stall_cycles
  );

  // Environment side (dispatch + exec + context management)
  modport master (
    output in_valid, in_info, accepted, flush,
    input  in_ready, order, exec_info, count, empty, full, stall_cycles
  );
endinterface

// File: rtl/exec_issue_fifo.sv
// In-order issue buffer in front of exec: circular storage, whole-buffer flush,
// and a saturating counter of cycles where the head was offered but not taken.
module exec_issue_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INFO_W = 32
) (
  input  logic            clk,
  input  logic            rstn,
  exec_issue_fifo_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INFO_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       stall_q, stall_d;

  logic empty, full, in_ready, order, push, pop;

  // Full/empty come only from the occupancy register, never pointer equality.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  // No push-through when full: a same-cycle pop frees the slot only next cycle.
  assign in_ready = ~full & ~bus.flush;
  assign order    = ~empty & ~bus.flush;
  assign push     = bus.in_valid & in_ready;
  assign pop      = order & bus.accepted;

  assign bus.in_ready     = in_ready;
  assign bus.order        = order;
  assign bus.exec_info    = empty ? '0 : mem_q[rp_q];
  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.stall_cycles = stall_q;

  // Next-state for pointers, occupancy and stall counter; flush wins over push/pop.
  always_comb begin
    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;
    stall_d = stall_q;
    if (bus.flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_W'(1);
      if (pop)  rp_d = rp_q + PTR_W'(1);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
    // Flush does not clear the counter; it saturates rather than wraps.
    if (order && !bus.accepted && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Control state, cleared asynchronously so reset drops entries at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage; contents are don't-care while empty since exec_info is gated.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.in_info;
  end

endmodule

// File: doc/exec_issue_fifo.md
# exec_issue_fifo

In-order issue buffer that sits directly upstream of the exec stage. It holds packed exec_info words from dispatch and presents the oldest one to exec through the order/accepted handshake. It drops its whole contents on a pipeline flush raised by context management after a jump or a taken-branch hazard. It also keeps a saturating count of cycles in which an instruction was offered but not accepted.

## Interface
- DEPTH, 4, number of entries; power of two, 2..16
- INFO_W, `LEN_EXEC_INFO, width of one packed exec_info word
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  asynchronous, active-low reset
- in_valid  in  1  dispatch offers in_info this cycle
- in_ready  out  1  buffer can take an entry this cycle
- in_info  in  INFO_W  packed exec_info from dispatch
- order  out  1  head entry offered to exec
- accepted  in  1  exec took the head entry this cycle (combinational from exec)
- exec_info  out  INFO_W  head entry; all zeros when empty
- flush  in  1  discard all entries (jump / branch hazard)
- count  out  CNT_W  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- stall_cycles  out  32  cycles with order=1 and accepted=0; saturates at 32'hFFFF_FFFF

## Operation
- Storage is a circular array of DEPTH entries with read pointer rp and write pointer wp, each log2(DEPTH) bits wide and wrapping modulo DEPTH. count is held in a separate register.
- push = in_valid & in_ready. Writes in_info at wp, then wp+1.
- in_ready = ~full & ~flush. There is no same-cycle push-through when full: a pop in the same cycle does not open a slot until the next cycle.
- order = ~empty & ~flush. exec_info = mem[rp] when ~empty, else 0.
- pop = order & accepted. Advances rp by 1. accepted with order=0 is ignored.
- Count update: push & ~pop gives +1; pop & ~push gives -1; push & pop leaves count unchanged. The block never overflows or underflows.
- flush has priority over everything. On the next edge rp=wp=0 and count=0. The push and the pop in the flush cycle are both suppressed: in_ready and order are both 0 during flush. Entry contents need not be cleared.
- stall_cycles increments whenever order & ~accepted, including while exec is busy. It is not cleared by flush and saturates instead of wrapping.
- Reset (rstn=0, asynchronous):
  - rp=wp=count=0 and stall_cycles=0.
  - Outputs: order=0, exec_info=0, empty=1, full=0, in_ready=1 (subject to flush).
- Reset during operation discards every entry immediately, without waiting for a clock edge.

## Timing
- Write-to-issue latency is 1 cycle. An entry pushed at edge N can be offered from the cycle after N. There is no bypass from in_info to exec_info.
- Issue throughput is one entry per cycle when exec accepts every cycle. After a pop, the next entry is visible on exec_info in the following cycle, combinationally from the updated rp.
- order and exec_info stay stable across cycles until accepted or flush. exec may leave the head unaccepted for any number of cycles.
- flush takes effect combinationally on order and in_ready in the cycle it is asserted. State is cleared at the following edge, and the first push after that is accepted in the next cycle.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Full and empty are decided only from count, never from pointer equality.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with accepted tied to order -> exec_info shows 0x11, 0x22, 0x33 on consecutive cycles starting 1 cycle after the first push; count ends at 0 and stall_cycles=0.
- DEPTH=4, accepted=0, push 5 entries -> in_ready drops after the 4th; full=1 and count=4; the 5th entry is not taken; stall_cycles increments every cycle order=1.
- From full, assert accepted and in_valid together -> the pop happens but no push; count=3. The next cycle pushes and count returns to 4. Entries keep FIFO order across the rp/wp wrap.
- Three entries queued, pulse flush for one cycle while in_valid=1 and accepted=1 -> order=0 and in_ready=0 in that cycle; next cycle count=0, empty=1, exec_info=0; the following push appears normally.
- Hold order=1 with accepted=0 for 10 cycles, then accept -> stall_cycles=10; a subsequent flush leaves it at 10.
- Drop rstn asynchronously mid-stream with 2 entries queued -> count=0 and order=0 immediately, without waiting for a clock edge; after release, the first push issues 1 cycle later.
